// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl: IF/ID and PC sequencing for branches, load-use, mult/div and imem wait.
// Revision: 1.0
`default_nettype none

module ifid_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q;
  logic        luh;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign luh = ex_memread & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    md_busy     = 1'b0;
    if (reset) begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (md_start) begin
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = MD_WAIT;
            cnt_d       = CNT_INIT;
          end else if (luh) begin
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
          end else if (!imem_ready) begin
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b0;
          end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
          end
        end
        MD_WAIT: begin
          ifid_flush  = 1'b0;
          idex_bubble = 1'b1;
          md_busy     = 1'b1;
          cnt_d       = cnt_q - 4'd1;
          // <= guards against a stuck wait if cnt ever reaches 0 here
          if (cnt_q <= 4'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed self-checking bench for ifid_hazard_ctrl (MD_CYCLES = 4).
`default_nettype none

module tb_ifid_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, branch_taken, md_start, imem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, md_busy;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  ifid_hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .md_start(md_start), .imem_ready(imem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic br, input logic md, input logic mr, input logic [4:0] ert,
                        input logic [4:0] irs, input logic [4:0] irt, input logic urt,
                        input logic rdy);
    branch_taken = br; md_start = md; ex_memread = mr; ex_rt = ert;
    id_rs = irs; id_rt = irt; id_uses_rt = urt; imem_ready = rdy;
  endtask

  // expected order: {pc_en, ifid_en, ifid_flush, idex_bubble, md_busy}
  task automatic chk_out(input string tag, input logic [4:0] exp_v);
    logic [4:0] obs;
    #1;
    obs = {pc_en, ifid_en, ifid_flush, idex_bubble, md_busy};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_stall(input string tag, input logic [15:0] exp_v);
    vectors++;
    assert (stall_cycles === exp_v) else begin
      miscompares++;
      $error("FAIL %s stall_cycles observed=%h expected=%h", tag, stall_cycles, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("reset_out0", 5'b00110);
    chk_stall("reset_stall0", 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset_out", 5'b00110);
      chk_stall("reset_stall", 16'd0);
    end
    reset = 1'b1;
    chk_out("release", 5'b11000);
    tick();
    chk_stall("release_stall", 16'd0);

    set_in(0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1);
    chk_out("luh_rs", 5'b00010);
    tick();
    chk_stall("luh_rs_stall", 16'd1);
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("luh_after", 5'b11000);
    tick();
    chk_stall("luh_after_stall", 16'd1);

    set_in(0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("luh_r0", 5'b11000);
    tick();
    set_in(0, 0, 1, 5'd8, 5'd3, 5'd8, 0, 1);
    chk_out("luh_rt_unused", 5'b11000);
    tick();
    chk_stall("no_stall_cnt", 16'd1);
    set_in(0, 0, 1, 5'd8, 5'd3, 5'd8, 1, 1);
    chk_out("luh_rt_used", 5'b00010);
    tick();
    chk_stall("luh_rt_stall", 16'd2);

    set_in(1, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1);
    chk_out("branch_over_luh", 5'b11110);
    tick();
    chk_stall("branch_stall", 16'd2);
    set_in(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    chk_out("branch_over_imem", 5'b11110);
    tick();
    chk_stall("branch_imem_stall", 16'd2);

    set_in(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("md_c1", 5'b00010);
    tick();
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("md_c2", 5'b00011);
    tick();
    set_in(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("md_c3_branch_ignored", 5'b00011);
    tick();
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("md_c4", 5'b00011);
    tick();
    chk_out("md_c5", 5'b11000);
    chk_stall("md_stall", 16'd6);
    tick();

    set_in(0, 1, 1, 5'd8, 5'd8, 5'd0, 0, 1);
    chk_out("md_over_luh", 5'b00010);
    tick();
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("md_luh_c2", 5'b00011);
    tick();
    reset = 1'b0;
    chk_out("md_abort_reset", 5'b00110);
    chk_stall("md_abort_stall", 16'd0);
    tick();
    reset = 1'b1;
    chk_out("md_abort_run", 5'b11000);
    tick();
    chk_stall("md_abort_run_stall", 16'd0);

    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      chk_out("imem_wait", 5'b01100);
      tick();
      chk_stall("imem_wait_stall", 16'(i));
    end
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("imem_resume", 5'b11000);
    tick();
    chk_stall("imem_resume_stall", 16'd3);

    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (65540) tick();
    chk_stall("sat", 16'hFFFF);
    chk_out("sat_out", 5'b01100);
    repeat (3) tick();
    chk_stall("sat_hold", 16'hFFFF);
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk_out("sat_resume", 5'b11000);
    tick();
    chk_stall("sat_final", 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
